muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the multicycle processor datapath. It serves MULT, MULTU, DIV and DIVU and writes a 2×WIDTH result into HI/LO. It replaces the fixed 32-bit Booth multiplier and adds:
- an unsigned mode
- a divider
- an explicit start/busy/done handshake toward the control unit

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits; must be ≥4 and even.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when not busy.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; latched with start.
- `a`  in  WIDTH  multiplicand / dividend; latched with start.
- `b`  in  WIDTH  multiplier / divisor; latched with start.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when HI/LO (or div_zero) valid.
- `hi`  out  WIDTH  product upper half / remainder.
- `lo`  out  WIDTH  product lower half / quotient.
- `div_zero`  out  1  last accepted divide had b==0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1:
  - Latch op, a, b.
  - Clear div_zero.
  - Load iteration counter with WIDTH.
  - Go to RUN.
- Divide with b==0 (checked at accept): go to DONE directly, set div_zero=1; hi/lo keep previous values.
- RUN:
  - One iteration per cycle; counter decrements.
  - Counter reaching 0 → DONE.
- DONE: hi/lo registered, done=1 for exactly this cycle; then IDLE unless start=1.
- MULT: radix-2 Booth on a 2·WIDTH+1 accumulator with arithmetic right shift; exact signed 2·WIDTH product.
- MULTU: shift-add on zero-extended operands; exact unsigned 2·WIDTH product.
- DIV/DIVU: restoring division on magnitudes, WIDTH iterations.
  - Signed: quotient truncates toward zero and is negated if operand signs differ; remainder takes the dividend's sign.
  - Signed overflow (a = most-negative, b = −1): lo = most-negative, hi = 0; no flag.
- start while busy: ignored, operands not relatched.
- op/a/b changes during RUN: no effect.
- Reset (any state, including mid-RUN):
  - IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0.
  - Accumulators cleared; no done pulse for the aborted operation.

## Timing
- start sampled at edge T.
- busy=1 from after T through edge T+WIDTH (WIDTH RUN cycles).
- done=1 and hi/lo new after edge T+WIDTH+1; busy=0 in that cycle.
- Latency start→done: WIDTH+1 cycles (33 for WIDTH=32), independent of operand values.
- Divide-by-zero: done after edge T+1 (latency 1).
- Back-to-back: start asserted during the DONE cycle is accepted; the next done comes WIDTH+1 cycles later.
- hi/lo: change only in DONE; otherwise hold.
- div_zero: holds from DONE until the next accepted start.

## Configuration
- `MULDIV_DIV_EN` defined: divider compiled in, behaviour as above.
- `MULDIV_DIV_EN` undefined:
  - No divider datapath.
  - Every op with op[1]=1 takes the divide-by-zero path: DONE after 1 cycle, div_zero=1, hi/lo unchanged.
  - MULT/MULTU unchanged.

## Test plan
- WIDTH=32, MULT a=FFFFFFFD, b=00000007 → hi=FFFFFFFF, lo=FFFFFFEB; done exactly 33 cycles after start; busy high 32 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001; then MULT same operands → hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=100, b=7 → lo=0000000E, hi=00000002.
- DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- DIVU a=5, b=0 after a prior result → done 1 cycle after start, div_zero=1, hi/lo retain prior values; next MULT clears div_zero.
- Start MULT, pulse reset at RUN cycle 10 → busy=0, hi=lo=0, no done.
- start pulsed while busy → ignored, original result returned.
- Start during DONE cycle → accepted; back-to-back result correct.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit writing a 2*WIDTH result into HI/LO.
//   MULT  : radix-2 Booth, signed product
//   MULTU : shift-add, unsigned product
//   DIV   : restoring division on magnitudes, signed fix-up at the end
//   DIVU  : restoring division, unsigned
// Optional feature macro: MULDIV_DIV_EN (divider datapath). When undefined, every
// op with op[1]=1 completes after one cycle with div_zero set and HI/LO untouched.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, op, a, b request and operands, latched when not busy
//   busy            high while iterating
//   done            one-cycle pulse when hi/lo (or div_zero) valid
//   hi, lo          product upper/lower half, or remainder/quotient
//   div_zero        last accepted divide had b==0
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  // Accumulator: {upper (WIDTH+1), lower (WIDTH), booth bit}. The extra upper bit
  // keeps Booth exact for the most-negative multiplicand and holds the carry of MULTU.
  localparam int unsigned AW = 2*WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q;
  logic [1:0]       op_q;
  logic             zero_q, busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH:0]   up;
  logic [WIDTH-1:0] low;
  logic             accept, zero_path;

  assign up     = acc_q[AW-1:WIDTH+1];
  assign low    = acc_q[WIDTH:1];
  assign accept = start && (state_q != RUN);

`ifdef MULDIV_DIV_EN
  logic             negq_q, negr_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign zero_path = op[1] && (b == '0);

  always_comb begin
    a_neg = (op == 2'b10) && a[WIDTH-1];
    b_neg = (op == 2'b10) && b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end
`else
  assign zero_path = op[1];
`endif

  // One iteration of the selected algorithm.
  always_comb begin
    logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   shl;
    logic [WIDTH+1:0] trial;
    shl   = '0;
    trial = '0;
`endif
    sum   = up;
    acc_d = acc_q;
    case (op_q)
      2'b00: begin
        case (acc_q[1:0])
          2'b01:   sum = up + {m_q[WIDTH-1], m_q};
          2'b10:   sum = up - {m_q[WIDTH-1], m_q};
          default: sum = up;
        endcase
        acc_d = {sum[WIDTH], sum, low};
      end
      2'b01: begin
        if (acc_q[1]) sum = up + {1'b0, m_q};
        acc_d = {1'b0, sum, low};
      end
`ifdef MULDIV_DIV_EN
      default: begin
        // Trial subtraction needs one bit beyond the shifted remainder to see the sign.
        shl   = {up[WIDTH-1:0], low[WIDTH-1]};
        trial = {1'b0, shl} - {2'b00, m_q};
        if (!trial[WIDTH+1]) acc_d = {trial[WIDTH:0], low[WIDTH-2:0], 1'b1, 1'b0};
        else                 acc_d = {shl, low[WIDTH-2:0], 1'b0, 1'b0};
      end
`else
      default: acc_d = acc_q;
`endif
    endcase
  end

  always_comb begin
    res_hi = acc_q[2*WIDTH:WIDTH+1];
    res_lo = acc_q[WIDTH:1];
`ifdef MULDIV_DIV_EN
    if (op_q[1]) begin
      res_lo = negq_q ? -low : low;
      res_hi = negr_q ? -up[WIDTH-1:0] : up[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          if (zero_q) dz_q <= 1'b1;
          else        {hi_q, lo_q} <= {res_hi, res_lo};
        end
        default: ;
      endcase

      if (accept) begin
        op_q   <= op;
        cnt_q  <= CW'(WIDTH);
        zero_q <= zero_path;
        // A divide-by-zero finishing this edge keeps its flag alongside its done pulse.
        if (!(state_q == DONE && zero_q)) dz_q <= 1'b0;
        state_q <= zero_path ? DONE : RUN;
        busy_q  <= !zero_path;
`ifdef MULDIV_DIV_EN
        if (op[1]) begin
          acc_q  <= {{(WIDTH+1){1'b0}}, a_mag, 1'b0};
          m_q    <= b_mag;
          negq_q <= a_neg ^ b_neg;
          negr_q <= a_neg;
        end else begin
          acc_q <= {{(WIDTH+1){1'b0}}, b, 1'b0};
          m_q   <= a;
        end
`else
        acc_q <= {{(WIDTH+1){1'b0}}, b, 1'b0};
        m_q   <= a;
`endif
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32), table vectors
// plus hand-written sequences; expectations queued on issue, compared on done.
module tb_muldiv_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi, lo, phi, plo;
    logic         dz;
    int           lat;
  } exp_t;
  exp_t sbq[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, ehi, elo;
  } vec_t;
  vec_t tab[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference {hi,lo} from native 64-bit arithmetic.
  function automatic logic [2*W-1:0] ref_calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: ref_calc = sx * sy;
      2'b01: ref_calc = ux * uy;
      2'b10: begin
        if (y == '0) ref_calc = '0;
        else begin
          q = sx / sy; r = sx % sy;
          ref_calc = {r[W-1:0], q[W-1:0]};
        end
      end
      default: begin
        if (y == '0) ref_calc = '0;
        else begin
          uq = ux / uy; ur = ux % uy;
          ref_calc = {ur[W-1:0], uq[W-1:0]};
        end
      end
    endcase
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    bit zp;
    zp = o[1] && (y == '0 || !DIV_EN);
    e.phi = m_hi;
    e.plo = m_lo;
    if (zp) begin
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.hi = ehi; e.lo = elo; e.dz = 1'b0; e.lat = W + 1;
    end
    m_hi = e.hi;
    m_lo = e.lo;
    sbq.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_result(input string tag, input bit pulse_chk, input int poke);
    exp_t e;
    int n, bc;
    bit hold_ok, seen;
    n = 0; bc = 0; hold_ok = 1'b1; seen = 1'b0;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sbq.pop_front();
    while (n < 200) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      if (hi !== e.phi || lo !== e.plo) hold_ok = 1'b0;
      if (poke >= 0) begin
        if (n == poke) begin start = 1'b1; op = 2'b01; a = $urandom; b = $urandom; end
        else start = 1'b0;
      end
      n++;
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, ".latency"}, 64'(n), 64'(e.lat));
      chk({tag, ".busy_cycles"}, 64'(bc), 64'(e.lat - 1));
      chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, ".hold"}, 64'(hold_ok), 64'd1);
      chk({tag, ".hi"}, 64'(hi), 64'(e.hi));
      chk({tag, ".lo"}, 64'(lo), 64'(e.lo));
      chk({tag, ".div_zero"}, 64'(div_zero), 64'(e.dz));
      if (pulse_chk) begin
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".dz_hold"}, 64'(div_zero), 64'(e.dz));
      end
    end
  endtask

  initial begin
    logic [2*W-1:0] r;
    logic [1:0]     ro;
    logic [W-1:0]   ra, rb;
    int             stray;

    tab[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tab[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tab[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tab[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tab[4]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    tab[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tab[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tab[7]  = '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    tab[8]  = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    tab[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tab[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    tab[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    tab[12] = '{2'b11, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      issue(tab[i].op, tab[i].a, tab[i].b, tab[i].ehi, tab[i].elo);
      wait_result($sformatf("vec%0d", i), 1'b1, -1);
    end

    // Divide by zero keeps the previous result; the next multiply clears the flag.
    issue(2'b11, 32'd5, 32'd0, '0, '0);
    wait_result("divzero", 1'b1, -1);
    issue(2'b00, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_result("after_dz", 1'b1, -1);

    // start while busy must be ignored.
    r = ref_calc(2'b00, 32'h12345678, 32'h9ABCDEF0);
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, r[2*W-1:W], r[W-1:0]);
    wait_result("busy_start", 1'b1, 5);

    // New start in the done cycle is accepted immediately.
    r = ref_calc(2'b01, 32'hDEADBEEF, 32'h0000F00D);
    issue(2'b01, 32'hDEADBEEF, 32'h0000F00D, r[2*W-1:W], r[W-1:0]);
    wait_result("b2b_first", 1'b0, -1);
    r = ref_calc(2'b00, 32'hFFFF0000, 32'h00012345);
    issue(2'b00, 32'hFFFF0000, 32'h00012345, r[2*W-1:W], r[W-1:0]);
    wait_result("b2b_second", 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? '0 : $urandom;
      r  = ref_calc(ro, ra, rb);
      issue(ro, ra, rb, r[2*W-1:W], r[W-1:0]);
      wait_result($sformatf("rand%0d", i), 1'b1, -1);
    end

    // Reset in the middle of a multiply: no done pulse, outputs cleared.
    issue(2'b00, 32'd7, 32'd9, 32'd0, 32'd63);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.done", 64'(done), 64'd0);
    chk("midreset.hi", 64'(hi), 64'd0);
    chk("midreset.lo", 64'(lo), 64'd0);
    chk("midreset.div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    sbq.delete();
    m_hi = '0; m_lo = '0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("midreset.no_done", 64'(stray), 64'd0);

    issue(tab[0].op, tab[0].a, tab[0].b, tab[0].ehi, tab[0].elo);
    wait_result("post_reset", 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
